// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a word-wide data memory. One access is in flight
// at a time; partial stores become a read-merge-write sequence.
module dm_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        Clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [3:0]  p0_be,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [3:0]  p1_be,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,

    output logic [31:0] MemAddr,
    output logic [31:0] Memdata,
    output logic        MemWrite,
    input  logic [31:0] Memout,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        any_req;
    logic        win_port;
    logic        win_we;
    logic [3:0]  win_be;
    logic [29:0] win_word;
    logic [31:0] win_wdata;

    logic        cur_port;
    logic        cur_we;
    logic [3:0]  cur_be;
    logic [29:0] cur_word;
    logic [31:0] cur_wdata;

    logic        last_grant;
    logic [1:0]  gnt_q;
    logic [1:0]  gnt_nxt;
    logic [1:0]  done_q;
    logic [1:0]  done_nxt;
    logic        mem_write_q;
    logic        mem_write_nxt;

    logic        take_req;
    logic        capture_rd;
    logic        capture_merge;
    logic [31:0] merge_data;
    logic [31:0] merge_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        in_mem_phase;

    // Word access only: the byte offset of the address carries no meaning here.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

    // Winner selection; only consulted while IDLE with a request present.
    always_comb begin
        any_req = p0_req | p1_req;
        if (FAIR != 0) begin
            if (p0_req && p1_req) begin
                win_port = ~last_grant;
            end else begin
                win_port = p1_req;
            end
        end else begin
            win_port = ~p0_req;
        end
    end

    always_comb begin
        if (win_port) begin
            win_we    = p1_we;
            win_be    = p1_be;
            win_word  = p1_addr[31:2];
            win_wdata = p1_wdata;
        end else begin
            win_we    = p0_we;
            win_be    = p0_be;
            win_word  = p0_addr[31:2];
            win_wdata = p0_wdata;
        end
    end

    // Lanes enabled by the store take new data, the rest keep the memory word.
    always_comb begin
        merge_data = Memout;
        for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) begin
                merge_data[8*i +: 8] = cur_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = 2'b00;
        done_nxt      = 2'b00;
        mem_write_nxt = 1'b0;
        take_req      = 1'b0;
        capture_rd    = 1'b0;
        capture_merge = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    take_req          = 1'b1;
                    state_nxt         = ACCESS;
                    gnt_nxt[win_port] = 1'b1;
                    mem_write_nxt     = win_we && (win_be == 4'hF);
                end
            end
            ACCESS: begin
                if (cur_we && (cur_be != 4'hF) && (cur_be != 4'h0)) begin
                    capture_merge = 1'b1;
                    mem_write_nxt = 1'b1;
                    state_nxt     = MERGE_WR;
                end else begin
                    capture_rd         = ~cur_we;
                    done_nxt[cur_port] = 1'b1;
                    state_nxt          = DONE;
                end
            end
            MERGE_WR: begin
                done_nxt[cur_port] = 1'b1;
                state_nxt          = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            mem_write_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            gnt_q       <= gnt_nxt;
            done_q      <= done_nxt;
            mem_write_q <= mem_write_nxt;
        end
    end

    // last_grant starts at port 1 so that port 0 takes the first tie.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_we     <= 1'b0;
            cur_be     <= 4'h0;
            cur_word   <= 30'd0;
            cur_wdata  <= 32'd0;
        end else if (take_req) begin
            last_grant <= win_port;
            cur_port   <= win_port;
            cur_we     <= win_we;
            cur_be     <= win_be;
            cur_word   <= win_word;
            cur_wdata  <= win_wdata;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            merge_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            if (capture_merge) begin
                merge_q <= merge_data;
            end
            if (capture_rd) begin
                if (cur_port) begin
                    rdata1_q <= Memout;
                end else begin
                    rdata0_q <= Memout;
                end
            end
        end
    end

    assign in_mem_phase = (state == ACCESS) || (state == MERGE_WR);

    always_comb begin
        MemAddr = 32'd0;
        Memdata = 32'd0;
        if (in_mem_phase) begin
            MemAddr = {cur_word, 2'b00};
        end
        if (mem_write_q) begin
            Memdata = (state == MERGE_WR) ? merge_q : cur_wdata;
        end
    end

    assign MemWrite  = mem_write_q;
    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_done   = done_q[0];
    assign p1_done   = done_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: cycle timeline model of the round-robin instance plus
// directed accesses with literal expectations; a fixed-priority instance shares inputs.
module tb_dm_arbiter;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;

    logic        p0_req = 1'b0;
    logic        p0_we = 1'b0;
    logic [3:0]  p0_be = 4'h0;
    logic [31:0] p0_addr = 32'd0;
    logic [31:0] p0_wdata = 32'd0;
    logic        p1_req = 1'b0;
    logic        p1_we = 1'b0;
    logic [3:0]  p1_be = 4'h0;
    logic [31:0] p1_addr = 32'd0;
    logic [31:0] p1_wdata = 32'd0;

    logic        p0_gnt, p0_done, p1_gnt, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] MemAddr, Memdata, Memout;
    logic        MemWrite;
    logic [1:0]  dbg_state;

    logic        f_p0_gnt, f_p0_done, f_p1_gnt, f_p1_done;
    logic [31:0] f_p0_rdata, f_p1_rdata;
    logic [31:0] f_mem_addr, f_mem_data, f_memout;
    logic        f_mem_write;
    logic [1:0]  f_dbg_state;

    logic [31:0] mem     [0:1023];
    logic [31:0] mem_f   [0:1023];
    logic [31:0] ref_mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 Clk = ~Clk;

    dm_arbiter #(.FAIR(1)) u_dut (
        .Clk(Clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .MemAddr(MemAddr), .Memdata(Memdata), .MemWrite(MemWrite), .Memout(Memout),
        .dbg_state(dbg_state)
    );

    dm_arbiter #(.FAIR(0)) u_fix (
        .Clk(Clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(f_p0_gnt), .p0_done(f_p0_done), .p0_rdata(f_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(f_p1_gnt), .p1_done(f_p1_done), .p1_rdata(f_p1_rdata),
        .MemAddr(f_mem_addr), .Memdata(f_mem_data), .MemWrite(f_mem_write), .Memout(f_memout),
        .dbg_state(f_dbg_state)
    );

    assign Memout   = mem[MemAddr[11:2]];
    assign f_memout = mem_f[f_mem_addr[11:2]];

    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddr[11:2]] = Memdata;
        if (f_mem_write) mem_f[f_mem_addr[11:2]] = f_mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Each granted access is expanded into per-cycle expectations in a small ring.
    int          cur = 0;
    int          next_ok = 0;
    logic        m_last = 1'b1;
    logic [1:0]  s_gnt  [0:7];
    logic [1:0]  s_done [0:7];
    logic        s_mw   [0:7];
    logic [31:0] s_ma   [0:7];
    logic [31:0] s_md   [0:7];
    logic        s_rv   [0:7];
    logic        s_rp   [0:7];
    logic [31:0] s_rd   [0:7];
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;

    function automatic void clear_slot(input int i);
        s_gnt[i] = 2'b00; s_done[i] = 2'b00; s_mw[i] = 1'b0;
        s_ma[i] = 32'd0; s_md[i] = 32'd0;
        s_rv[i] = 1'b0; s_rp[i] = 1'b0; s_rd[i] = 32'd0;
    endfunction

    always @(posedge Clk or negedge reset) begin : model
        int i0, i1, i2;
        logic w, we;
        logic [3:0] be;
        logic [31:0] wa, wd, old, merged;
        if (!reset) begin
            for (int i = 0; i < 8; i++) clear_slot(i);
            exp_rd0 = 32'd0;
            exp_rd1 = 32'd0;
            m_last  = 1'b1;
            next_ok = 0;
        end else begin
            i0 = cur & 7;
            if (s_mw[i0]) ref_mem[s_ma[i0][11:2]] = s_md[i0];
            clear_slot(i0);
            cur = cur + 1;
            i0 = cur & 7;
            if (s_rv[i0]) begin
                if (s_rp[i0]) exp_rd1 = s_rd[i0];
                else exp_rd0 = s_rd[i0];
            end
            if (cur >= next_ok && (p0_req || p1_req)) begin
                if (p0_req && p1_req) w = !m_last;
                else if (p1_req) w = 1'b1;
                else w = 1'b0;
                m_last = w;
                we = w ? p1_we : p0_we;
                be = w ? p1_be : p0_be;
                wa = w ? p1_addr : p0_addr;
                wa[1:0] = 2'b00;
                wd = w ? p1_wdata : p0_wdata;
                old = ref_mem[wa[11:2]];
                i1 = (cur + 1) & 7;
                i2 = (cur + 2) & 7;
                s_gnt[i0][w] = 1'b1;
                s_ma[i0] = wa;
                next_ok = cur + 3;
                if (!we) begin
                    s_done[i1][w] = 1'b1;
                    s_rv[i1] = 1'b1; s_rp[i1] = w; s_rd[i1] = old;
                end else if (be == 4'hF) begin
                    s_mw[i0] = 1'b1; s_md[i0] = wd;
                    s_done[i1][w] = 1'b1;
                end else if (be == 4'h0) begin
                    s_done[i1][w] = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++)
                        merged[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
                    s_ma[i1] = wa; s_mw[i1] = 1'b1; s_md[i1] = merged;
                    s_done[i2][w] = 1'b1;
                    next_ok = cur + 4;
                end
            end
        end
    end

    always @(negedge Clk) begin : compare
        int i;
        if (chk_en) begin
            i = cur & 7;
            check("cyc p0_gnt",   {31'd0, p0_gnt},   {31'd0, s_gnt[i][0]});
            check("cyc p1_gnt",   {31'd0, p1_gnt},   {31'd0, s_gnt[i][1]});
            check("cyc p0_done",  {31'd0, p0_done},  {31'd0, s_done[i][0]});
            check("cyc p1_done",  {31'd0, p1_done},  {31'd0, s_done[i][1]});
            check("cyc MemWrite", {31'd0, MemWrite}, {31'd0, s_mw[i]});
            check("cyc MemAddr",  MemAddr,  s_ma[i]);
            check("cyc Memdata",  Memdata,  s_md[i]);
            check("cyc p0_rdata", p0_rdata, exp_rd0);
            check("cyc p1_rdata", p1_rdata, exp_rd1);
        end
    end

    // ---------------- driver ----------------
    task automatic set_port(input logic port, input logic req, input logic we,
                            input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic do_access(input logic port, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int gnt_cyc, output int done_cyc, output int n_wr,
                             output logic [31:0] wr_addr, output logic [31:0] wr_data);
        gnt_cyc = -1; done_cyc = -1; n_wr = 0; wr_addr = 32'd0; wr_data = 32'd0;
        set_port(port, 1'b1, we, be, addr, wdata);
        for (int k = 1; k <= 12; k++) begin
            @(posedge Clk); #1;
            if (MemWrite) begin
                n_wr++; wr_addr = MemAddr; wr_data = Memdata;
            end
            if ((port ? p1_gnt : p0_gnt) && gnt_cyc < 0) begin
                gnt_cyc = k;
                if (port) p1_req = 1'b0; else p0_req = 1'b0;
            end
            if (port ? p1_done : p0_done) begin
                done_cyc = k;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL access_timeout: port %0d got no done within 12 cycles, expected one", port);
            if (port) p1_req = 1'b0; else p0_req = 1'b0;
        end
        @(posedge Clk); #1;
    endtask

    int          g, d, nw;
    logic [31:0] wa, wd;
    int          seq_main[$];
    int          seq_fix[$];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA5A50000 | i;
        end
        mem[2]  = 32'h11223344;
        mem[4]  = 32'hDEADBEEF;
        mem[12] = 32'hCAFEF00D;
        for (int i = 0; i < 1024; i++) begin
            mem_f[i] = mem[i];
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 8; i++) clear_slot(i);

        reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_en = 1'b1;
        check("reset MemAddr", MemAddr, 32'd0);
        check("reset MemWrite", {31'd0, MemWrite}, 32'd0);
        check("reset p0_rdata", p0_rdata, 32'd0);
        check("reset p1_gnt", {31'd0, p1_gnt}, 32'd0);
        @(posedge Clk); #1;
        reset = 1'b1;
        @(posedge Clk); #1;

        // p0 load
        do_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, g, d, nw, wa, wd);
        check("load gnt cycle", g, 1);
        check("load done cycle", d, 2);
        check("load rdata", p0_rdata, 32'hDEADBEEF);
        check("load writes", nw, 0);

        // p1 full store
        do_access(1'b1, 1'b1, 4'hF, 32'h24, 32'h12345678, g, d, nw, wa, wd);
        check("full gnt cycle", g, 1);
        check("full done cycle", d, 2);
        check("full writes", nw, 1);
        check("full addr", wa, 32'h24);
        check("full data", wd, 32'h12345678);

        // p0 partial store
        do_access(1'b0, 1'b1, 4'b0010, 32'h8, 32'h0000AB00, g, d, nw, wa, wd);
        check("part gnt cycle", g, 1);
        check("part done cycle", d, 3);
        check("part writes", nw, 1);
        check("part addr", wa, 32'h8);
        check("part data", wd, 32'h1122AB44);

        // empty store leaves memory alone
        do_access(1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, g, d, nw, wa, wd);
        check("empty done cycle", d, 2);
        check("empty writes", nw, 0);
        do_access(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, g, d, nw, wa, wd);
        check("empty readback", p1_rdata, 32'hDEADBEEF);

        // low address bits ignored; rdata held per port
        do_access(1'b1, 1'b0, 4'h0, 32'h27, 32'h0, g, d, nw, wa, wd);
        check("unaligned load", p1_rdata, 32'h12345678);
        check("p0 rdata held", p0_rdata, 32'hDEADBEEF);
        do_access(1'b0, 1'b0, 4'h0, 32'h8, 32'h0, g, d, nw, wa, wd);
        check("merge readback", p0_rdata, 32'h1122AB44);
        check("p1 rdata held", p1_rdata, 32'h12345678);

        // reset during MERGE_WR
        set_port(1'b0, 1'b1, 1'b1, 4'b1000, 32'h30, 32'h99000000);
        @(posedge Clk); #1;
        check("abort gnt", {31'd0, p0_gnt}, 32'd1);
        p0_req = 1'b0;
        @(posedge Clk); #1;
        check("abort merge write", {31'd0, MemWrite}, 32'd1);
        check("abort merge data", Memdata, 32'h99FEF00D);
        reset = 1'b0;
        #1;
        check("abort MemWrite", {31'd0, MemWrite}, 32'd0);
        check("abort MemAddr", MemAddr, 32'd0);
        check("abort Memdata", Memdata, 32'd0);
        @(posedge Clk); #1;
        check("abort no done", {31'd0, p0_done}, 32'd0);
        @(posedge Clk); #1;
        reset = 1'b1;
        check("abort mem intact", mem[12], 32'hCAFEF00D);
        do_access(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, g, d, nw, wa, wd);
        check("after abort gnt", g, 1);
        check("after abort done", d, 2);
        check("after abort rdata", p1_rdata, 32'hCAFEF00D);

        // both ports requesting continuously from reset
        @(posedge Clk); #1;
        reset = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk); #1;
            if (p0_gnt) seq_main.push_back(0);
            if (p1_gnt) seq_main.push_back(1);
            if (f_p0_gnt) seq_fix.push_back(0);
            if (f_p1_gnt) seq_fix.push_back(1);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("fair grant count", seq_main.size(), 7);
        check("fixed grant count", seq_fix.size(), 7);
        if (seq_main.size() >= 4) begin
            check("fair grant 0", seq_main[0], 0);
            check("fair grant 1", seq_main[1], 1);
            check("fair grant 2", seq_main[2], 0);
            check("fair grant 3", seq_main[3], 1);
        end
        for (int i = 0; i < seq_fix.size(); i++) begin
            check("fixed grant port", seq_fix[i], 0);
        end

        repeat (5) @(posedge Clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter FAIR, default 1, meaning: 1 = round-robin between ports, 0 = fixed priority with port 0 winning.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pN_req  input  1  request from port N (N = 0,1); held by requester until pN_gnt.
REQ-005 pN_we  input  1  1 = store, 0 = load.
REQ-006 pN_be  input  4  byte enables for a store; bit i selects bits [8i+7:8i]; ignored on loads.
REQ-007 pN_addr  input  32  byte address; bits [1:0] ignored (word access).
REQ-008 pN_wdata  input  32  store data, byte-lane aligned.
REQ-009 pN_gnt  output  1  one-cycle pulse: request of port N accepted and latched.
REQ-010 pN_done  output  1  one-cycle pulse: access of port N complete.
REQ-011 pN_rdata  output  32  load result; valid in pN_done cycle, held until next completed load on that port.
REQ-012 MemAddr  output  32  address to dm.
REQ-013 Memdata  output  32  write data to dm.
REQ-014 MemWrite  output  1  write strobe to dm.
REQ-015 Memout  input  32  combinational read data from dm.

Function
REQ-016 States: IDLE, ACCESS, MERGE_WR, DONE; all outputs except MemAddr/Memdata are registered.
REQ-017 IDLE: at an edge with any pN_req high, arbiter selects winner, latches its we/be/addr/wdata and port id, moves to ACCESS; no req -> stay IDLE.
REQ-018 Arbitration, FAIR=1: single requester wins; both requesting -> port other than last_grant wins; last_grant updates on every grant.
REQ-019 Arbitration, FAIR=0: port 0 wins whenever p0_req is high.
REQ-020 pN_gnt high for exactly the first cycle of ACCESS, for the winner only; loser's request stays pending, unlatched.
REQ-021 ACCESS, load: at its end edge capture Memout into winner's rdata, go DONE; MemWrite 0.
REQ-022 ACCESS, store be=4'hF: MemWrite=1, Memdata=latched wdata for the ACCESS cycle, go DONE.
REQ-023 ACCESS, store be=4'h0: MemWrite 0, go DONE (no memory change).
REQ-024 ACCESS, store partial be: MemWrite 0; at end edge latch merge = per byte be[i] ? wdata byte : Memout byte, go MERGE_WR.
REQ-025 MERGE_WR: MemWrite=1, Memdata=merge, go DONE.
REQ-026 DONE: pN_done=1 for winner for one cycle, go IDLE; requests are not sampled in DONE.
REQ-027 MemAddr = {latched addr[31:2], 2'b00} in ACCESS and MERGE_WR, 0 otherwise; Memdata 0 when MemWrite 0.
REQ-028 Latency from req-sampling edge E0: gnt cycle 1, done cycle 2 (load/full/empty store) or cycle 3 (partial store); next grant earliest cycle 4 (DONE then IDLE sample).
REQ-029 MemWrite never asserted outside ACCESS (full store) or MERGE_WR; at most one write cycle per granted access.
REQ-030 A pN_req still high in IDLE after that port's done is a new request.
REQ-031 Arbiter does not drive dm's own reset; address wrap above 4 KB is dm's behaviour and is not checked here.

Reset
REQ-032 reset low, any time, immediately forces: state IDLE, all pN_gnt/pN_done/MemWrite 0, MemAddr/Memdata 0, pN_rdata 0, last_grant = 1 (port 0 wins first tie).
REQ-033 Reset mid-ACCESS or mid-MERGE_WR aborts the access: no write, no done; first edge after release behaves as IDLE.

Verification
REQ-034 p0 load addr 0x10, Memout 0xDEADBEEF -> p0_gnt cycle 1, p0_done cycle 2, p0_rdata 0xDEADBEEF, MemWrite never 1.
REQ-035 p1 store addr 0x24 be 4'hF data 0x12345678 -> MemWrite 1 for one cycle with MemAddr 0x24, Memdata 0x12345678; p1_done cycle 2.
REQ-036 p0 store addr 0x8 be 4'b0010 data 0x0000AB00, Memout 0x11223344 -> single MemWrite in MERGE_WR with Memdata 0x1122AB44; p0_done cycle 3.
REQ-037 FAIR=1, both ports requesting continuously from reset -> grants alternate 0,1,0,1; FAIR=0 same stimulus -> all grants port 0.
REQ-038 reset low during MERGE_WR -> MemWrite 0 immediately, no done pulse, next request after release served normally.
